// File: rtl/cntr4dg_ctrl_if.sv
// ---------------------------------------------------------------------------
// cntr4dg_ctrl_if
//   Groups the button/mode inputs and the display-driver outputs of the
//   4-digit counter control stage.
//
//   Signals:
//     I_BTN_UP, I_BTN_DN, I_BTN_CLR : raw push buttons, active-high, async
//     I_HEX                         : mode select (0 = BCD, 1 = hex), async
//     I_LZB                         : leading-zero blanking enable
//     O_DG3..O_DG0                  : digit nibbles, DG3 most significant
//     O_DOTS                        : decimal points, {3'b000, hex mode}
//     O_DRVEN                       : digit enables, active-high
//     O_WRAP                        : one-cycle pulse on counter wrap-around
//
//   Modports:
//     master : drives the buttons and observes the outputs (bench / board)
//     slave  : the counter control block itself
// ---------------------------------------------------------------------------
interface cntr4dg_ctrl_if;
  logic       I_BTN_UP;
  logic       I_BTN_DN;
  logic       I_BTN_CLR;
  logic       I_HEX;
  logic       I_LZB;
  logic [3:0] O_DG3;
  logic [3:0] O_DG2;
  logic [3:0] O_DG1;
  logic [3:0] O_DG0;
  logic [3:0] O_DOTS;
  logic [3:0] O_DRVEN;
  logic       O_WRAP;

  modport master (
    output I_BTN_UP, I_BTN_DN, I_BTN_CLR, I_HEX, I_LZB,
    input  O_DG3, O_DG2, O_DG1, O_DG0, O_DOTS, O_DRVEN, O_WRAP
  );

  modport slave (
    input  I_BTN_UP, I_BTN_DN, I_BTN_CLR, I_HEX, I_LZB,
    output O_DG3, O_DG2, O_DG1, O_DG0, O_DOTS, O_DRVEN, O_WRAP
  );
endinterface

// File: rtl/cntr4dg_ctrl.sv
// ---------------------------------------------------------------------------
// cntr4dg_ctrl
//   Counter and control stage feeding a 4-digit multiplexed 7-segment driver.
//   Raw buttons and the mode switch are synchronised (2 flops) and debounced;
//   rising edges of the debounced UP/DN/CLR become one-cycle press events that
//   step a 4-digit BCD or hex up/down counter. Outputs carry the digits, the
//   dot pattern and the digit-enable mask with optional leading-zero blanking.
//
//   Parameters:
//     DEB_CYCLES : stable cycles required to accept a level change (2..65535)
//     DEB_W      : debounce counter width, must hold DEB_CYCLES-1
//
//   Ports:
//     I_CLK   : system clock
//     I_RESET : asynchronous reset, active-high
//     bus     : cntr4dg_ctrl_if.slave (buttons, mode, LZB in; display out)
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module cntr4dg_ctrl #(
  parameter int DEB_CYCLES = 7812,
  parameter int DEB_W      = 16
) (
  input  logic          I_CLK,
  input  logic          I_RESET,
  cntr4dg_ctrl_if.slave bus
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Bit positions of the four conditioned inputs.
  localparam int IN_UP  = 0;
  localparam int IN_DN  = 1;
  localparam int IN_CLR = 2;
  localparam int IN_HEX = 3;

  // -------------------------------------------------------------------------
  // Two-stage synchroniser for all four asynchronous inputs
  // -------------------------------------------------------------------------
  logic [3:0] raw_in;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  assign raw_in = {bus.I_HEX, bus.I_BTN_CLR, bus.I_BTN_DN, bus.I_BTN_UP};

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-input debounce: the counter runs only while the synced level differs
  // from the accepted level; reaching DEB_CYCLES-1 with the levels still
  // different accepts the new level. Any return to agreement restarts it, so
  // shorter glitches are swallowed.
  // -------------------------------------------------------------------------
  logic [3:0] deb_lvl;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_q, cnt_d;
      logic             lvl_q, lvl_d;

      always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (sync2_q[gi] == lvl_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          lvl_d = sync2_q[gi];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end

      always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
        end
      end

      assign deb_lvl[gi] = lvl_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Edge detection on the debounced levels
  // -------------------------------------------------------------------------
  logic [3:0] deb_dly_q, deb_dly_d;
  logic       up_ev_q, up_ev_d;
  logic       dn_ev_q, dn_ev_d;
  logic       clr_ev_q, clr_ev_d;
  logic       mode_chg;

  always_comb begin
    deb_dly_d = deb_lvl;
    up_ev_d   = deb_lvl[IN_UP]  & ~deb_dly_q[IN_UP];
    dn_ev_d   = deb_lvl[IN_DN]  & ~deb_dly_q[IN_DN];
    clr_ev_d  = deb_lvl[IN_CLR] & ~deb_dly_q[IN_CLR];
  end

  // A mode flip (either direction) is seen here on the cycle right after the
  // debounced level moves, so the counter is cleared on that same edge. Any
  // arithmetic done before this point still used the old mode's digit limit,
  // so no out-of-range digit can appear in the new mode.
  assign mode_chg = deb_lvl[IN_HEX] ^ deb_dly_q[IN_HEX];

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      deb_dly_q <= 4'b0000;
      up_ev_q   <= 1'b0;
      dn_ev_q   <= 1'b0;
      clr_ev_q  <= 1'b0;
    end else begin
      deb_dly_q <= deb_dly_d;
      up_ev_q   <= up_ev_d;
      dn_ev_q   <= dn_ev_d;
      clr_ev_q  <= clr_ev_d;
    end
  end

  // -------------------------------------------------------------------------
  // 4-digit counter with per-digit carry/borrow chain
  // -------------------------------------------------------------------------
  logic [3:0][3:0] dig_q, dig_d;
  logic            wrap_q, wrap_d;
  logic [3:0]      drven_q, drven_d;
  logic [3:0]      dots_q, dots_d;
  logic [3:0]      lim;
  logic            carry;

  always_comb begin
    dig_d  = dig_q;
    wrap_d = 1'b0;
    carry  = 1'b0;
    lim    = deb_lvl[IN_HEX] ? 4'hF : 4'h9;

    if (clr_ev_q || mode_chg) begin
      dig_d = '0;
    end else if (up_ev_q && dn_ev_q) begin
      // Simultaneous up and down cancel out.
      dig_d = dig_q;
    end else if (up_ev_q) begin
      // Carry ripples upward through every digit sitting at its limit.
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (dig_q[i] == lim) begin
            dig_d[i] = 4'h0;
          end else begin
            dig_d[i] = dig_q[i] + 4'h1;
            carry    = 1'b0;
          end
        end
      end
      // Carry out of the top digit means every digit was at its limit.
      wrap_d = carry;
    end else if (dn_ev_q) begin
      // Borrow ripples upward through every zero digit.
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (dig_q[i] == 4'h0) begin
            dig_d[i] = lim;
          end else begin
            dig_d[i] = dig_q[i] - 4'h1;
            carry    = 1'b0;
          end
        end
      end
      wrap_d = carry;
    end
  end

  // -------------------------------------------------------------------------
  // Display side: blanking is computed from the next digits so the enables
  // always line up with the digits they describe. I_LZB is quasi-static and
  // is used directly.
  // -------------------------------------------------------------------------
  always_comb begin
    if (!bus.I_LZB) begin
      drven_d = 4'b1111;
    end else begin
      drven_d[3] = (dig_d[3] != 4'h0);
      drven_d[2] = ((dig_d[3] | dig_d[2]) != 4'h0);
      drven_d[1] = ((dig_d[3] | dig_d[2] | dig_d[1]) != 4'h0);
      drven_d[0] = 1'b1;
    end
    dots_d = {3'b000, deb_lvl[IN_HEX]};
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      dig_q   <= '0;
      wrap_q  <= 1'b0;
      drven_q <= 4'b0001;
      dots_q  <= 4'b0000;
    end else begin
      dig_q   <= dig_d;
      wrap_q  <= wrap_d;
      drven_q <= drven_d;
      dots_q  <= dots_d;
    end
  end

  assign bus.O_DG3   = dig_q[3];
  assign bus.O_DG2   = dig_q[2];
  assign bus.O_DG1   = dig_q[1];
  assign bus.O_DG0   = dig_q[0];
  assign bus.O_DOTS  = dots_q;
  assign bus.O_DRVEN = drven_q;
  assign bus.O_WRAP  = wrap_q;

endmodule

// File: tb/tb_cntr4dg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cntr4dg_ctrl
//   Self-checking bench for cntr4dg_ctrl with DEB_CYCLES=4. The reference is
//   an integer count with modular arithmetic (mod 10000 or 65536); digits and
//   blanking are derived from that value arithmetically.
// ---------------------------------------------------------------------------
module tb_cntr4dg_ctrl;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cntr4dg_ctrl_if bus();

  cntr4dg_ctrl #(.DEB_CYCLES(DEB), .DEB_W(16)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_val   = 0;
  bit m_hex   = 1'b0;
  bit m_lzb   = 1'b1;
  int m_wraps = 0;

  // Observed wrap activity
  int          wrap_cnt = 0;
  int          wrap_mis = 0;
  logic [15:0] prev_dg  = 16'h0;
  logic [15:0] dg;

  assign dg = {bus.O_DG3, bus.O_DG2, bus.O_DG1, bus.O_DG0};

  // Every wrap pulse must coincide with a change of the displayed count.
  always @(negedge clk) begin
    if (!rst && bus.O_WRAP) begin
      wrap_cnt++;
      if (dg == prev_dg) wrap_mis++;
    end
    prev_dg = dg;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int base_of();
    return m_hex ? 16 : 10;
  endfunction

  function automatic logic [15:0] exp_dg();
    logic [15:0] r;
    int v;
    int b;
    b = base_of();
    v = m_val;
    r = 16'h0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % b);
      v = v / b;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_drven();
    int b;
    b = base_of();
    if (!m_lzb) return 4'b1111;
    return {m_val >= b*b*b, m_val >= b*b, m_val >= b, 1'b1};
  endfunction

  function automatic void model_apply(input bit up, input bit dn, input bit clr);
    int top;
    top = m_hex ? 65535 : 9999;
    if (clr) m_val = 0;
    else if (up && dn) m_val = m_val;
    else if (up) begin
      if (m_val == top) begin m_val = 0; m_wraps++; end
      else m_val++;
    end else if (dn) begin
      if (m_val == 0) begin m_val = top; m_wraps++; end
      else m_val--;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a button combination for 'hold' cycles, then release and settle.
  task automatic press(input bit up, input bit dn, input bit clr, input int hold);
    bus.I_BTN_UP  = up;
    bus.I_BTN_DN  = dn;
    bus.I_BTN_CLR = clr;
    tick(hold);
    bus.I_BTN_UP  = 1'b0;
    bus.I_BTN_DN  = 1'b0;
    bus.I_BTN_CLR = 1'b0;
    tick(12);
  endtask

  task automatic step(input bit up, input bit dn, input bit clr);
    press(up, dn, clr, 14);
    model_apply(up, dn, clr);
  endtask

  task automatic set_hex(input bit h);
    bus.I_HEX = h;
    tick(14);
    if (h != m_hex) m_val = 0;
    m_hex = h;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dg"},    32'(dg),          32'(exp_dg()));
    chk({tag, "_drven"}, 32'(bus.O_DRVEN), 32'(exp_drven()));
    chk({tag, "_dots"},  32'(bus.O_DOTS),  {31'b0, m_hex});
    chk({tag, "_wraps"}, 32'(wrap_cnt),    32'(m_wraps));
    $display("op %-12s count=%04h drven=%b dots=%b wraps=%0d", tag, dg, bus.O_DRVEN, bus.O_DOTS, wrap_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dg"},    32'(dg),          32'h0);
    chk({tag, "_dots"},  32'(bus.O_DOTS),  32'h0);
    chk({tag, "_drven"}, 32'(bus.O_DRVEN), 32'h1);
    chk({tag, "_wrap"},  32'(bus.O_WRAP),  32'h0);
  endtask

  initial begin
    int r;
    bus.I_BTN_UP  = 1'b0;
    bus.I_BTN_DN  = 1'b0;
    bus.I_BTN_CLR = 1'b0;
    bus.I_HEX     = 1'b0;
    bus.I_LZB     = 1'b1;
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(3);

    // Exact latency: count moves on the 8th clock after the raw edge.
    bus.I_BTN_UP = 1'b1;
    tick(7);
    chk("lat_cycle7", 32'(dg), 32'h0);
    tick(1);
    chk("lat_cycle8", 32'(dg), 32'h1);
    chk("lat_drven",  32'(bus.O_DRVEN), 32'h1);
    chk("lat_dots",   32'(bus.O_DOTS),  32'h0);
    tick(12);
    bus.I_BTN_UP = 1'b0;
    tick(12);
    m_val = 1;
    check_all("first");

    // Short glitch, then a long hold counting exactly once.
    press(1'b1, 1'b0, 1'b0, 3);
    check_all("glitch3");
    press(1'b1, 1'b0, 1'b0, 20);
    model_apply(1'b1, 1'b0, 1'b0);
    check_all("hold20");

    // BCD wrap down and back up.
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check_all("bcd_dn_wrap");
    step(1'b1, 1'b0, 1'b0);
    check_all("bcd_up_wrap");

    // Hex mode entry clears 0042; hex wraps and no BCD carry at 9.
    repeat (42) step(1'b1, 1'b0, 1'b0);
    check_all("bcd_0042");
    set_hex(1'b1);
    check_all("hex_clear");
    step(1'b0, 1'b1, 1'b0);
    check_all("hex_dn_wrap");
    step(1'b1, 1'b0, 1'b0);
    check_all("hex_up_wrap");
    repeat (9) step(1'b1, 1'b0, 1'b0);
    check_all("hex_0009");
    step(1'b1, 1'b0, 1'b0);
    check_all("hex_000a");

    // Simultaneous presses.
    step(1'b1, 1'b1, 1'b0);
    check_all("up_and_dn");
    step(1'b1, 1'b0, 1'b1);
    check_all("clr_and_up");

    // Blanking on 0105, then LZB off takes effect on the next edge.
    set_hex(1'b0);
    repeat (105) step(1'b1, 1'b0, 1'b0);
    check_all("lzb_0105");
    bus.I_LZB = 1'b0;
    m_lzb = 1'b0;
    tick(1);
    chk("lzb_off_next", 32'(bus.O_DRVEN), 32'hF);

    // Randomised operations.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1: step(1'b1, 1'b0, 1'b0);
        2:    step(1'b0, 1'b1, 1'b0);
        3:    step(1'b0, 1'b0, 1'b1);
        4:    step(1'b1, 1'b1, 1'b0);
        5:    press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0,
                    int'($urandom_range(1, DEB - 1)));
        6:    set_hex(~m_hex);
        default: begin
          m_lzb = ~m_lzb;
          bus.I_LZB = m_lzb;
          tick(2);
        end
      endcase
      check_all($sformatf("rnd%0d_%0d", n, r));
    end

    // Reset in the middle of a debounce aborts the pending press.
    set_hex(1'b0);
    bus.I_BTN_UP = 1'b1;
    tick(5);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    bus.I_BTN_UP = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);
    m_val = 0;
    check_all("after_rst");

    chk("wrap_align", 32'(wrap_mis), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cntr4dg_ctrl.md
Name: cntr4dg_ctrl

Overview:
- Counter and control stage directly upstream of the 4-digit multiplexed 7-segment driver.
- Takes raw push-button inputs, synchronises and debounces them, and maintains a 4-digit up/down counter in BCD or hex mode.
- Produces per-digit nibbles, dot pattern and digit-enable mask with leading-zero blanking.
- All outputs are registered and connect straight to the driver's DG3..DG0, DOTS and DRVEN inputs.

Parameters:
- DEB_CYCLES, 7812, number of consecutive stable cycles needed to accept a button level change (20 ms at 390.625 kHz); legal range 2..65535.
- DEB_W, 16, width of the debounce counter; must hold DEB_CYCLES-1.

Ports:
- I_CLK  input  1  system clock.
- I_RESET  input  1  asynchronous reset, active-high.
- I_BTN_UP  input  1  raw increment button, active-high, asynchronous to I_CLK.
- I_BTN_DN  input  1  raw decrement button, active-high, asynchronous.
- I_BTN_CLR  input  1  raw clear button, active-high, asynchronous.
- I_HEX  input  1  mode select (0 = BCD 0000..9999, 1 = hex 0000..FFFF), asynchronous.
- I_LZB  input  1  leading-zero blanking enable, quasi-static.
- O_DG3  output  4  most significant digit.
- O_DG2  output  4  digit 2.
- O_DG1  output  4  digit 1.
- O_DG0  output  4  least significant digit.
- O_DOTS  output  4  decimal points, active-high; equal to {3'b000, hex mode}.
- O_DRVEN  output  4  digit enables, active-high.
- O_WRAP  output  1  one-cycle pulse on any wrap-around.

Behaviour:
- Reset: I_RESET is asynchronous, active-high; the clock is I_CLK. While in reset all digits are 0, O_DOTS=4'b0000, O_DRVEN=4'b0001 and O_WRAP=0. All synchroniser, debounce and edge registers clear to 0. Assertion mid-count aborts any pending press.
- Synchroniser: each of the four raw inputs passes through 2 flip-flop stages.
- Debounce, per input:
  - Counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter equals DEB_CYCLES-1 and the levels still differ, the debounced level takes the synced level on that edge and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced level.
- Edge detect: a press event is a registered one-cycle pulse on the rising edge of the debounced UP, DN or CLR. Releases generate nothing.
- Mode: the debounced I_HEX is the mode. Any change of mode, in either direction, clears the count to 0000 on the cycle after the debounced change.
- Counter update happens on the edge after the press pulse. Priority:
  1. CLR or mode change -> 0000.
  2. UP and DN pulses in the same cycle -> no change.
  3. UP -> +1.
  4. DN -> -1.
- Arithmetic:
  - Per-digit carry/borrow chain; digit limit is 9 in BCD mode and F in hex mode.
  - Up from 9999 (BCD) or FFFF (hex) wraps to 0000.
  - Down from 0000 wraps to 9999 or FFFF.
  - A wrap asserts O_WRAP for exactly one cycle, aligned with the new count.
  - Digit values above 9 never appear in BCD mode.
- Latency: raw rising edge held stable -> 2 sync cycles + DEB_CYCLES debounce + 1 edge register + 1 count register. The counter changes DEB_CYCLES+4 cycles after the raw edge, sampled at the first clock after the edge.
- Blanking (registered, updated with the digits):
  - I_LZB=0: O_DRVEN=4'b1111.
  - I_LZB=1: O_DRVEN[3]=0 if DG3==0; O_DRVEN[2]=0 if DG3 and DG2 are both 0; O_DRVEN[1]=0 if DG3, DG2 and DG1 are all 0; otherwise the bit is 1.
  - O_DRVEN[0] is always 1.
  - A change of I_LZB takes effect on the next edge; it is not debounced.
- Held button: counts once per press, with no auto-repeat. A new press needs a debounced release followed by a debounced press.

Test Plan:
- Run all tests with DEB_CYCLES=4. Reset, then raise I_BTN_UP and hold 20 cycles -> count 0001 at exactly cycle 8 after the edge, O_DRVEN=4'b0001 (I_LZB=1), O_DOTS=0000.
- Pulse UP high for 3 cycles only -> count unchanged. Hold UP for 20 cycles -> exactly one increment.
- BCD: preload by pressing UP 9999 times, or DN once from 0000 -> 9999 with O_WRAP pulsed one cycle. Then UP -> 0000 with O_WRAP pulsed, O_DRVEN=4'b0001.
- Set I_HEX=1 with count 0042 -> count 0000 and O_DOTS=4'b0001 after debounce. DN -> FFFF with O_WRAP. UP from 0009 -> 000A (no BCD carry).
- Debounced UP and DN rise on the same cycle -> no change. CLR pressed together with UP -> 0000.
- Count 0105 with I_LZB=1 -> O_DRVEN=4'b0111; set I_LZB=0 -> 4'b1111 on the next edge. Assert I_RESET mid-debounce -> all outputs at reset values immediately, and the pending press never counts.
